// File: rtl/sync_merge_arb6.sv
// Six-way round-robin, packet-locked merge arbiter with a registered output stage.
// Define SYNC_MERGE_ARB6_FIXED_PRIO_EN for lowest-index-wins arbitration instead.
module sync_merge_arb6 #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              i_valid,
  input  logic [5:0]              i_last,
  input  logic [6*DATA_WIDTH-1:0] i_data,
  output logic [5:0]              o_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_last,
  output logic [2:0]              o_src,
  input  logic                    i_ready,
  output logic                    o_busy
);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              ptr_q, ptr_d;
  logic [2:0]              lock_id_q, lock_id_d;
  logic                    o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0]   o_data_q, o_data_d;
  logic                    o_last_q, o_last_d;
  logic [2:0]              o_src_q, o_src_d;

  logic                    can_load;
  logic                    win_found;
  logic [2:0]              win_id;
  logic [2:0]              gnt_id;
  logic                    xfer;
  logic                    gnt_last;
  logic [DATA_WIDTH-1:0]   gnt_data;

  assign can_load = ~o_valid_q | i_ready;

`ifdef SYNC_MERGE_ARB6_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    for (int n = 5; n >= 0; n--) begin
      if (i_valid[n]) begin
        win_found = 1'b1;
        win_id    = 3'(n);
      end
    end
  end
`else
  // Circular search starting one past the last winner.
  always_comb begin
    logic [2:0] idx;
    win_found = 1'b0;
    win_id    = 3'd0;
    idx       = ptr_q;
    for (int k = 0; k < 6; k++) begin
      idx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      if (!win_found && i_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end
`endif

  // Output process: grant and busy decode.
  always_comb begin
    o_ready = 6'b0;
    unique case (state_q)
      StIdle: if (win_found) o_ready[win_id] = can_load;
      StLock: o_ready[lock_id_q] = can_load;
    endcase
    if (rst) o_ready = 6'b0;
  end

  assign o_busy = (state_q == StLock);

  assign gnt_id   = (state_q == StLock) ? lock_id_q : win_id;
  assign xfer     = |(i_valid & o_ready);
  assign gnt_last = i_last[gnt_id];

  always_comb begin
    gnt_data = '0;
    for (int n = 0; n < 6; n++) begin
      if (gnt_id == 3'(n)) gnt_data = i_data[n*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state process.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_id_d = lock_id_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          ptr_d = win_id;
          if (!gnt_last) begin
            lock_id_d = win_id;
            state_d   = StLock;
          end
        end
      end
      StLock: begin
        if (xfer && gnt_last) state_d = StIdle;
      end
    endcase
  end

  // Output stage: a load beats a simultaneous drain.
  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    o_src_d   = o_src_q;
    if (xfer) begin
      o_valid_d = 1'b1;
      o_data_d  = gnt_data;
      o_last_d  = gnt_last;
      o_src_d   = gnt_id;
    end else if (i_ready) begin
      o_valid_d = 1'b0;
    end
  end

  // State register process.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 3'd5;
      lock_id_q <= 3'd0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_src_q   <= 3'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_id_q <= lock_id_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      o_src_q   <= o_src_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_last  = o_last_q;
  assign o_src   = o_src_q;

endmodule

// File: tb/tb_sync_merge_arb6.sv
// Bench for sync_merge_arb6: directed vector table, a reset-mid-packet sequence,
// and random traffic against a transaction-level reference model.
module tb_sync_merge_arb6;

  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [5:0]      i_valid;
  logic [5:0]      i_last;
  logic [6*DW-1:0] i_data;
  logic [5:0]      o_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic            o_last;
  logic [2:0]      o_src;
  logic            i_ready;
  logic            o_busy;

  sync_merge_arb6 #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_last  (i_last),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_src   (o_src),
    .i_ready (i_ready),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state (packet-level view of the arbiter).
  int          m_ptr;
  bit          m_lock;
  int          m_lid;
  bit          m_ov;
  logic [31:0] m_data;
  bit          m_last;
  int          m_src;
  bit          m_init = 0;

  logic [31:0] lane_d [6];

  function automatic logic [5:0] model_ready(input logic r, input logic [5:0] v, input logic rd);
    bit can;
    int w;
    can = !m_ov || rd;
    if (r || !can) return 6'b0;
    if (m_lock) return 6'(1 << m_lid);
    w = -1;
`ifdef SYNC_MERGE_ARB6_FIXED_PRIO_EN
    for (int k = 0; k < 6; k++) if (w < 0 && v[k]) w = k;
`else
    for (int k = 1; k <= 6; k++) if (w < 0 && v[(m_ptr + k) % 6]) w = (m_ptr + k) % 6;
`endif
    return (w < 0) ? 6'b0 : 6'(1 << w);
  endfunction

  task automatic cycle(input logic r, input logic [5:0] v, input logic [5:0] l, input logic rd,
                       output logic [5:0] seen);
    logic [5:0] mr;
    int g;
    rst = r; i_valid = v; i_last = l; i_ready = rd;
    for (int n = 0; n < 6; n++) i_data[n*DW +: DW] = lane_d[n];
    #1;
    mr   = model_ready(r, v, rd);
    seen = o_ready;
    chk("mdl_ready", 32'(o_ready), 32'(mr));
    if (m_init) begin
      chk("mdl_valid", 32'(o_valid), 32'(m_ov));
      chk("mdl_data", o_data, m_data);
      chk("mdl_last", 32'(o_last), 32'(m_last));
      chk("mdl_src", 32'(o_src), 32'(m_src));
      chk("mdl_busy", 32'(o_busy), 32'(m_lock));
    end
    @(posedge clk);
    if (r) begin
      m_ptr = 5; m_lock = 0; m_lid = 0; m_ov = 0; m_data = 0; m_last = 0; m_src = 0;
      m_init = 1;
    end else if ((v & mr) != 6'b0) begin
      g = 0;
      for (int n = 0; n < 6; n++) if (mr[n]) g = n;
      m_ov = 1; m_data = lane_d[g]; m_last = l[g]; m_src = g;
      if (!m_lock) begin
        m_ptr = g;
        if (!l[g]) begin m_lock = 1; m_lid = g; end
      end else if (l[g]) begin
        m_lock = 0;
      end
    end else if (rd) begin
      m_ov = 0;
    end
    #1;
  endtask

  typedef struct {
    logic        r;
    logic [5:0]  v;
    logic [5:0]  l;
    logic        rd;
    logic [31:0] d;
    logic [5:0]  er;
    logic        eov;
    logic [31:0] edata;
    logic [2:0]  esrc;
    logic        elast;
    logic        ebusy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [5:0] v, logic [5:0] l, logic rd, logic [31:0] d,
                              logic [5:0] er, logic eov, logic [31:0] edata, logic [2:0] esrc,
                              logic elast, logic ebusy);
    vec_t x;
    x.r = r; x.v = v; x.l = l; x.rd = rd; x.d = d; x.er = er; x.eov = eov;
    x.edata = edata; x.esrc = esrc; x.elast = elast; x.ebusy = ebusy;
    return x;
  endfunction

  initial begin
    logic [5:0] seen;
    rst = 1'b1; i_valid = '0; i_last = '0; i_ready = 1'b1; i_data = '0;

    // Reset held with all requesters valid.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 6'h3F, 6'h3F, 1, 32'h10, 6'h00, 0, 0, 0, 0, 0));
`ifdef SYNC_MERGE_ARB6_FIXED_PRIO_EN
    // Requesters 2 and 4 compete: 2 always wins.
    for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 6'h14, 6'h14, 1, 32'h10, 6'h04, 1, 32'h12, 2, 1, 0));
`else
    // Round-robin over six single-beat sources, no idle cycles.
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(0, 6'h3F, 6'h3F, 1, 32'h10, 6'(1 << (i % 6)), 1, 32'h10 + 32'(i % 6),
                        3'(i % 6), 1, 0));
    // Three-beat burst from requester 3 (lane data = d + 3).
    vecs.push_back(mk(0, 6'h08, 6'h00, 1, 32'h9E, 6'h08, 1, 32'hA1, 3, 0, 1));
    vecs.push_back(mk(0, 6'h08, 6'h00, 1, 32'h9F, 6'h08, 1, 32'hA2, 3, 0, 1));
    vecs.push_back(mk(0, 6'h08, 6'h08, 1, 32'hA0, 6'h08, 1, 32'hA3, 3, 1, 0));
    // Requester 1 four-beat packet with a 2-cycle gap; requester 0 waits.
    vecs.push_back(mk(0, 6'h02, 6'h00, 1, 32'h30, 6'h02, 1, 32'h31, 1, 0, 1));
    vecs.push_back(mk(0, 6'h03, 6'h00, 1, 32'h40, 6'h02, 1, 32'h41, 1, 0, 1));
    vecs.push_back(mk(0, 6'h01, 6'h00, 1, 32'h50, 6'h02, 0, 32'h41, 1, 0, 1));
    vecs.push_back(mk(0, 6'h01, 6'h00, 1, 32'h50, 6'h02, 0, 32'h41, 1, 0, 1));
    vecs.push_back(mk(0, 6'h03, 6'h00, 1, 32'h60, 6'h02, 1, 32'h61, 1, 0, 1));
    vecs.push_back(mk(0, 6'h03, 6'h02, 1, 32'h70, 6'h02, 1, 32'h71, 1, 1, 0));
    vecs.push_back(mk(0, 6'h01, 6'h01, 1, 32'h55, 6'h01, 1, 32'h55, 0, 1, 0));
    // Downstream stall holds 0x55, then load on release.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 6'h01, 6'h01, 0, 32'h99, 6'h00, 1, 32'h55, 0, 1, 0));
    vecs.push_back(mk(0, 6'h01, 6'h01, 1, 32'h99, 6'h01, 1, 32'h99, 0, 1, 0));
    vecs.push_back(mk(0, 6'h00, 6'h00, 1, 32'h99, 6'h00, 0, 32'h99, 0, 1, 0));
`endif

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      for (int n = 0; n < 6; n++) lane_d[n] = vecs[i].d + 32'(n);
      cycle(vecs[i].r, vecs[i].v, vecs[i].l, vecs[i].rd, seen);
      chk($sformatf("tbl%0d_ready", i), 32'(seen), 32'(vecs[i].er));
      chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(vecs[i].eov));
      chk($sformatf("tbl%0d_data", i), o_data, vecs[i].edata);
      chk($sformatf("tbl%0d_src", i), 32'(o_src), 32'(vecs[i].esrc));
      chk($sformatf("tbl%0d_last", i), 32'(o_last), 32'(vecs[i].elast));
      chk($sformatf("tbl%0d_busy", i), 32'(o_busy), 32'(vecs[i].ebusy));
    end

    // Reset in the middle of a packet from requester 2.
    for (int n = 0; n < 6; n++) lane_d[n] = 32'hC0 + 32'(n);
    cycle(0, 6'h04, 6'h00, 1, seen);
    chk("rstmid_locked", 32'(o_busy), 32'd1);
    cycle(1, 6'h3F, 6'h00, 1, seen);
    chk("rstmid_ready", 32'(seen), 32'd0);
    chk("rstmid_valid", 32'(o_valid), 32'd0);
    chk("rstmid_busy", 32'(o_busy), 32'd0);
    cycle(0, 6'h3F, 6'h3F, 1, seen);
    chk("rstmid_first_grant", 32'(seen), 32'h01);
    chk("rstmid_src", 32'(o_src), 32'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 6; n++) lane_d[n] = $urandom;
      cycle(($urandom_range(0, 199) == 0), 6'($urandom), 6'($urandom & $urandom),
            ($urandom_range(0, 3) != 0), seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
